// File: rtl/bcd_uart_tx_if.sv
// Handshake and serial-output bundle for bcd_uart_tx: the send strobe and digit
// snapshot source on one side, the UART line and status flags on the other.
interface bcd_uart_tx_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    send;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    txd;
    logic                    busy;
    logic                    done;

    modport master (output send, digits, input txd, busy, done);
    modport slave  (input send, digits, output txd, busy, done);
endinterface

// File: rtl/bcd_uart_tx.sv
// Snapshots a chain of BCD digits on a send strobe and streams them as ASCII
// over 8N1 UART, MS digit first, terminated by CR LF.
module bcd_uart_tx #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int NUM_DIGITS   = 4
) (
    input  logic         clk,
    input  logic         rst,
    bcd_uart_tx_if.slave bus
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(NUM_DIGITS + 2);
    localparam int SW = 4 * NUM_DIGITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state_q,  state_d;
    logic [BW-1:0] baud_q,   baud_d;
    logic [2:0]    bit_q,    bit_d;
    logic [CW-1:0] char_q,   char_d;
    logic [SW-1:0] shadow_q, shadow_d;
    logic          txd_q,    txd_d;
    logic          busy_q,   busy_d;
    logic          done_q,   done_d;

    logic          last_baud;
    logic [3:0]    cur_nib;
    logic [7:0]    cur_byte;

    // The shadow shifts left after each digit, so the current digit is always the top nibble.
    always_comb begin
        cur_nib = shadow_q[SW-1 -: 4];
        if (char_q < CW'(NUM_DIGITS))
            cur_byte = (cur_nib <= 4'd9) ? (8'h30 + {4'h0, cur_nib}) : 8'h3F;
        else if (char_q == CW'(NUM_DIGITS))
            cur_byte = 8'h0D;
        else
            cur_byte = 8'h0A;
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        char_d    = char_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;
        last_baud = (baud_q == BW'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    shadow_d = bus.digits;
                    char_d   = '0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (last_baud) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (last_baud) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (last_baud) begin
                    baud_d = '0;
                    if (char_q == CW'(NUM_DIGITS + 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        char_d   = char_q + CW'(1);
                        shadow_d = shadow_q << 4;
                        state_d  = START;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state drives on the line.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = cur_byte[bit_d];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            char_q   <= '0;
            // NOTE: the shadow is cleared too; it is a handful of flops, not a RAM, so reset is cheap.
            shadow_q <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            char_q   <= char_d;
            shadow_q <= shadow_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
